// File: rtl/uart_tx_serializer.sv
// UART transmitter: serializes one byte per valid/ready handshake into a frame of
// start bit, 8 data bits LSB-first, optional parity and 1 or 2 stop bits on a registered TXD.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       busy,
    output logic       tx_done
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_ZERO = {BAUD_W{1'b0}};
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("uart_tx_serializer: CLKS_PER_BIT must be >= 2");
        end
        if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
            $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        parity_bit = (^data) ^ odd;
    endfunction

    state_t            r_state;
    logic [BAUD_W-1:0] r_baud_cnt;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic              r_parity;
    logic              r_txd;
    logic              r_tx_done;

    state_t            w_state_next;
    logic [BAUD_W-1:0] w_baud_next;
    logic [2:0]        w_bit_next;
    logic [7:0]        w_shift_next;
    logic              w_parity_next;
    logic              w_txd_next;
    logic              w_tx_done_next;
    logic              w_bit_end;

    assign w_bit_end = (r_baud_cnt == BAUD_LAST);

    // Frame sequencing: next state, baud/bit counters and shift register
    always_comb begin
        w_state_next  = r_state;
        w_baud_next   = r_baud_cnt;
        w_bit_next    = r_bit_cnt;
        w_shift_next  = r_shift;
        w_parity_next = r_parity;
        case (r_state)
            S_IDLE: begin
                if (tx_valid) begin
                    w_state_next  = S_START;
                    w_baud_next   = BAUD_ZERO;
                    w_bit_next    = 3'd0;
                    w_shift_next  = tx_data;
                    w_parity_next = parity_bit(tx_data, (PARITY_ODD != 0));
                end else begin
                    w_state_next  = S_IDLE;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                    w_baud_next  = BAUD_ZERO;
                end else begin
                    w_baud_next  = r_baud_cnt + BAUD_ONE;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_next  = BAUD_ZERO;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit_cnt == 3'd7) begin
                        w_bit_next = 3'd0;
                        if (PARITY_EN != 0) begin
                            w_state_next = S_PARITY;
                        end else begin
                            w_state_next = S_STOP;
                        end
                    end else begin
                        w_bit_next = r_bit_cnt + 3'd1;
                    end
                end else begin
                    w_baud_next = r_baud_cnt + BAUD_ONE;
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = S_STOP;
                    w_baud_next  = BAUD_ZERO;
                end else begin
                    w_baud_next  = r_baud_cnt + BAUD_ONE;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_baud_next = BAUD_ZERO;
                    if (r_bit_cnt == STOP_LAST) begin
                        w_state_next = S_IDLE;
                        w_bit_next   = 3'd0;
                    end else begin
                        w_bit_next   = r_bit_cnt + 3'd1;
                    end
                end else begin
                    w_baud_next = r_baud_cnt + BAUD_ONE;
                end
            end
            default: begin
                w_state_next  = S_IDLE;
                w_baud_next   = BAUD_ZERO;
                w_bit_next    = 3'd0;
                w_shift_next  = 8'h00;
                w_parity_next = 1'b0;
            end
        endcase
    end

    // Line level and done strobe are computed for the cycle after the edge so both register cleanly
    always_comb begin
        w_txd_next = 1'b1;
        case (w_state_next)
            S_START:  w_txd_next = 1'b0;
            S_DATA:   w_txd_next = w_shift_next[0];
            S_PARITY: w_txd_next = w_parity_next;
            default:  w_txd_next = 1'b1;
        endcase
        w_tx_done_next = (w_state_next == S_STOP) && (w_bit_next == STOP_LAST)
                         && (w_baud_next == BAUD_LAST);
    end

    // State, counters and output registers with synchronous active-low reset
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= BAUD_ZERO;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            r_parity   <= 1'b0;
            r_txd      <= 1'b1;
            r_tx_done  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_baud_next;
            r_bit_cnt  <= w_bit_next;
            r_shift    <= w_shift_next;
            r_parity   <= w_parity_next;
            r_txd      <= w_txd_next;
            r_tx_done  <= w_tx_done_next;
        end
    end

    assign tx_ready = (r_state == S_IDLE);
    assign busy     = (r_state != S_IDLE);
    assign txd      = r_txd;
    assign tx_done  = r_tx_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: five configurations side by side, a frame-level
// reference model checked every cycle, a table of decoded frames and multi-cycle corner sequences.
module tb_uart_tx_serializer;

    localparam int NDUT = 5;

    // Configurations: 0=8N1, 1=8E1, 2=8O1, 3=8N2 (all 4 clk/bit), 4=8E2 at 2 clk/bit
    function automatic int cfg_cpb(input int i);
        if (i == 4) return 2;
        else return 4;
    endfunction
    function automatic int cfg_pen(input int i);
        if (i == 1 || i == 2 || i == 4) return 1;
        else return 0;
    endfunction
    function automatic int cfg_podd(input int i);
        if (i == 2) return 1;
        else return 0;
    endfunction
    function automatic int cfg_stop(input int i);
        if (i == 3 || i == 4) return 2;
        else return 1;
    endfunction

    logic            clk = 1'b0;
    logic            rst_n;
    logic [7:0]      tx_data_a [NDUT];
    logic [NDUT-1:0] tx_valid_v;
    logic [NDUT-1:0] tx_ready_v;
    logic [NDUT-1:0] txd_v;
    logic [NDUT-1:0] busy_v;
    logic [NDUT-1:0] tx_done_v;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        uart_tx_serializer #(
            .CLKS_PER_BIT(cfg_cpb(g)),
            .PARITY_EN   (cfg_pen(g)),
            .PARITY_ODD  (cfg_podd(g)),
            .STOP_BITS   (cfg_stop(g))
        ) u_dut (
            .clk_sys (clk),
            .rst_n   (rst_n),
            .tx_data (tx_data_a[g]),
            .tx_valid(tx_valid_v[g]),
            .tx_ready(tx_ready_v[g]),
            .txd     (txd_v[g]),
            .busy    (busy_v[g]),
            .tx_done (tx_done_v[g])
        );
    end

    // Reference model: per DUT, a list of expected {txd, tx_ready, busy, tx_done} per cycle of a frame
    logic [3:0] m_buf [NDUT][0:63];
    int         m_pos [NDUT];
    int         m_len [NDUT];
    logic [3:0] m_exp [NDUT];

    task automatic model_load(input int d, input logic [7:0] b);
        logic bits [$];
        int   cpb;
        cpb = cfg_cpb(d);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
        if (cfg_pen(d) != 0) bits.push_back(1'(($countones(b) + cfg_podd(d)) % 2));
        for (int i = 0; i < cfg_stop(d); i++) bits.push_back(1'b1);
        m_len[d] = bits.size() * cpb;
        m_pos[d] = 0;
        for (int k = 0; k < m_len[d]; k++)
            m_buf[d][k] = {bits[k / cpb], 1'b0, 1'b1, (k == m_len[d] - 1)};
    endtask

    task automatic model_edge();
        for (int d = 0; d < NDUT; d++) begin
            if (!rst_n) begin
                m_pos[d] = 0;
                m_len[d] = 0;
            end else if (m_pos[d] < m_len[d]) begin
                m_pos[d]++;
            end else if (tx_valid_v[d]) begin
                model_load(d, tx_data_a[d]);
            end
            m_exp[d] = (m_pos[d] < m_len[d]) ? m_buf[d][m_pos[d]] : 4'b1100;
        end
    endtask

    task automatic check_outputs();
        for (int d = 0; d < NDUT; d++) begin
            logic [3:0] act;
            act = {txd_v[d], tx_ready_v[d], busy_v[d], tx_done_v[d]};
            n_checks++;
            if (act !== m_exp[d]) begin
                n_errors++;
                $display("FAIL cycle_d%0d t=%0t: {txd,ready,busy,done} got %b expected %b",
                         d, $time, act, m_exp[d]);
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    // Sends one byte and samples txd every cycle from the handshake until tx_done
    task automatic capture_frame(input int d, input logic [7:0] b, input bit disturb,
                                 output int len, output logic [7:0] rx, output logic par,
                                 output int zeros, output bit ok);
        logic s [0:127];
        int   cpb;
        cpb = cfg_cpb(d);
        tx_data_a[d]  = b;
        tx_valid_v[d] = 1'b1;
        tick();
        tx_valid_v[d] = 1'b0;
        tx_data_a[d]  = 8'($urandom);
        len = 0; zeros = 0; ok = 1'b0;
        while (!ok && len < 120) begin
            s[len] = txd_v[d];
            if (!txd_v[d]) zeros++;
            len++;
            if (disturb && len == 3 * cpb) begin
                tx_data_a[d]  = 8'hFF;
                tx_valid_v[d] = 1'b1;
            end
            if (disturb && len == 6 * cpb) tx_valid_v[d] = 1'b0;
            if (tx_done_v[d]) ok = 1'b1;
            else tick();
        end
        for (int i = 0; i < 8; i++) rx[i] = s[(1 + i) * cpb + cpb / 2];
        par = s[9 * cpb + cpb / 2];
        tick();
    endtask

    typedef struct {
        int         dut;
        logic [7:0] data;
        int         exp_len;
        logic       exp_par;
        int         exp_zeros;
    } vec_t;

    vec_t vecs [9];

    task automatic run_back_to_back();
        logic       s [0:127];
        int         dones;
        int         run;
        logic [7:0] rx1;
        logic [7:0] rx2;
        tx_data_a[0]  = 8'h55;
        tx_valid_v[0] = 1'b1;
        tick();
        tx_data_a[0] = 8'hAA;
        dones = 0;
        for (int n = 0; n < 100; n++) begin
            s[n] = txd_v[0];
            if (tx_done_v[0]) dones++;
            if (n == 41) tx_valid_v[0] = 1'b0;
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            rx1[i] = s[(1 + i) * 4 + 2];
            rx2[i] = s[41 + (1 + i) * 4 + 2];
        end
        run = 0;
        for (int n = 36; n < 60 && s[n] === 1'b1; n++) run++;
        check("b2b_frame1_data", int'(rx1), 32'h55);
        check("b2b_frame2_data", int'(rx2), 32'hAA);
        check("b2b_done_pulses", dones, 2);
        // one stop bit of 4 cycles plus exactly one idle cycle
        check("b2b_stop_run", run, 5);
    endtask

    int         len;
    int         zeros;
    logic [7:0] rx;
    logic       par;
    bit         ok;
    int         done_seen;

    initial begin
        vecs[0] = '{dut: 0, data: 8'hA5, exp_len: 40, exp_par: 1'b0, exp_zeros: 20};
        vecs[1] = '{dut: 1, data: 8'h07, exp_len: 44, exp_par: 1'b1, exp_zeros: 24};
        vecs[2] = '{dut: 2, data: 8'h07, exp_len: 44, exp_par: 1'b0, exp_zeros: 28};
        vecs[3] = '{dut: 3, data: 8'h00, exp_len: 44, exp_par: 1'b0, exp_zeros: 36};
        vecs[4] = '{dut: 4, data: 8'hFF, exp_len: 24, exp_par: 1'b0, exp_zeros: 4};
        vecs[5] = '{dut: 4, data: 8'h80, exp_len: 24, exp_par: 1'b1, exp_zeros: 16};
        vecs[6] = '{dut: 0, data: 8'h00, exp_len: 40, exp_par: 1'b0, exp_zeros: 36};
        vecs[7] = '{dut: 2, data: 8'hFF, exp_len: 44, exp_par: 1'b1, exp_zeros: 4};
        vecs[8] = '{dut: 1, data: 8'hFF, exp_len: 44, exp_par: 1'b0, exp_zeros: 8};

        rst_n      = 1'b0;
        tx_valid_v = '0;
        for (int d = 0; d < NDUT; d++) tx_data_a[d] = 8'h00;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 9; i++) begin
            capture_frame(vecs[i].dut, vecs[i].data, 1'b0, len, rx, par, zeros, ok);
            check($sformatf("vec%0d_done_seen", i), int'(ok), 1);
            check($sformatf("vec%0d_frame_len", i), len, vecs[i].exp_len);
            check($sformatf("vec%0d_data", i), int'(rx), int'(vecs[i].data));
            check($sformatf("vec%0d_low_cycles", i), zeros, vecs[i].exp_zeros);
            if (cfg_pen(vecs[i].dut) != 0)
                check($sformatf("vec%0d_parity", i), int'(par), int'(vecs[i].exp_par));
        end

        run_back_to_back();
        repeat (3) tick();

        // Inputs changing mid-frame must not affect the accepted byte
        capture_frame(1, 8'h3C, 1'b1, len, rx, par, zeros, ok);
        check("disturb_done_seen", int'(ok), 1);
        check("disturb_data", int'(rx), 32'h3C);
        check("disturb_parity", int'(par), 0);
        repeat (3) tick();

        // One-cycle reset during DATA aborts the frame without a done pulse
        tx_data_a[0]  = 8'h00;
        tx_valid_v[0] = 1'b1;
        tick();
        tx_valid_v[0] = 1'b0;
        repeat (12) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_mid_txd", int'(txd_v[0]), 1);
        check("rst_mid_ready", int'(tx_ready_v[0]), 1);
        check("rst_mid_busy", int'(busy_v[0]), 0);
        done_seen = 0;
        for (int n = 0; n < 60; n++) begin
            tick();
            if (tx_done_v[0]) done_seen++;
        end
        check("rst_mid_no_done", done_seen, 0);
        capture_frame(0, 8'h96, 1'b0, len, rx, par, zeros, ok);
        check("after_rst_done_seen", int'(ok), 1);
        check("after_rst_data", int'(rx), 32'h96);
        check("after_rst_len", len, 40);

        // Randomized traffic on all configurations against the model, with rare resets
        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < NDUT; d++) begin
                tx_valid_v[d] = ($urandom_range(0, 2) == 0);
                tx_data_a[d]  = 8'($urandom);
            end
            rst_n = ($urandom_range(0, 399) != 0);
            tick();
        end
        rst_n      = 1'b1;
        tx_valid_v = '0;
        repeat (60) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
